// File: rtl/mrv1_pkg.sv
// Shared types for the MRV1 multiply/divide functional unit.
// Opcode encoding: bit 2 marks divide ops, bit 1 remainder, bit 0 unsigned.
package mrv1_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mrv_mul_fu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    function automatic logic is_div_op(input mrv_mul_fu_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/mrv1_div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Operands are made positive on entry and the signs are re-applied on the way out.
module mrv1_div_iter
    import mrv1_pkg::*;
#(
    parameter int W      = 32,
    parameter int ITAG_W = 3,
    parameter int TID_W  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic              rem_sel_i,
    input  logic [W-1:0]      dividend_i,
    input  logic [W-1:0]      divisor_i,
    input  logic [ITAG_W-1:0] itag_i,
    input  logic [TID_W-1:0]  tid_i,
    input  logic              wb_rdy_i,
    output logic              idle_o,
    output logic              done_o,
    output logic [W-1:0]      res_o,
    output logic [ITAG_W-1:0] itag_o,
    output logic [TID_W-1:0]  tid_o
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    div_state_e        state, state_n;
    logic [W-1:0]      quo, rem, dvs;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r, rem_sel;
    logic [ITAG_W-1:0] itag_q;
    logic [TID_W-1:0]  tid_q;

    logic              sign_a, sign_b, div_zero, ovf;
    logic [W-1:0]      abs_a, abs_b, q_fin, r_fin;
    logic [W:0]        shifted, diff;

    always_comb begin
        sign_a   = signed_i & dividend_i[W-1];
        sign_b   = signed_i & divisor_i[W-1];
        abs_a    = sign_a ? (~dividend_i + 1'b1) : dividend_i;
        abs_b    = sign_b ? (~divisor_i + 1'b1) : divisor_i;
        div_zero = (divisor_i == '0);
        ovf      = signed_i & (dividend_i == {1'b1, {(W-1){1'b0}}}) & (&divisor_i);
        shifted  = {rem, quo[W-1]};
        diff     = shifted - {1'b0, dvs};
        q_fin    = neg_q ? (~quo + 1'b1) : quo;
        r_fin    = neg_r ? (~rem + 1'b1) : rem;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= DIV_IDLE;
        else         state <= state_n;
    end

    // Divide-by-zero and MIN/-1 have fixed answers, so they skip the iteration.
    always_comb begin
        state_n = state;
        case (state)
            DIV_IDLE: if (start_i) state_n = (div_zero | ovf) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (cnt == '0) state_n = DIV_DONE;
            DIV_DONE: if (wb_rdy_i) state_n = DIV_IDLE;
            default:  state_n = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_sel <= 1'b0;
            itag_q  <= '0;
            tid_q   <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_i) begin
                        itag_q  <= itag_i;
                        tid_q   <= tid_i;
                        rem_sel <= rem_sel_i;
                        cnt     <= CNT_W'(W - 1);
                        neg_q   <= 1'b0;
                        neg_r   <= 1'b0;
                        if (div_zero) begin
                            quo <= '1;
                            rem <= dividend_i;
                        end else if (ovf) begin
                            quo <= dividend_i;
                            rem <= '0;
                        end else begin
                            quo   <= abs_a;
                            rem   <= '0;
                            dvs   <= abs_b;
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= sign_a;
                        end
                    end
                end
                DIV_CALC: begin
                    quo <= {quo[W-2:0], ~diff[W]};
                    rem <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign idle_o = (state == DIV_IDLE);
    assign done_o = (state == DIV_DONE);
    assign res_o  = rem_sel ? r_fin : q_fin;
    assign itag_o = itag_q;
    assign tid_o  = tid_q;

endmodule

// File: rtl/mrv1_muldiv_fu.sv
// MRV1 pipelined multiply FU with optional iterative divider sharing the ports.
// Define MRV1_MULDIV_DIV_EN to build the divider; otherwise divide ops return 0 after the mul latency.
module mrv1_muldiv_fu
    import mrv1_pkg::*;
#(
    parameter int DATA_WIDTH_P  = 32,
    parameter int ITAG_WIDTH_P  = 3,
    parameter int NUM_THREADS_P = 4,
    parameter int MUL_STAGES_P  = 2,
    localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH_P-1:0] exec_src0_data_i,
    input  logic [DATA_WIDTH_P-1:0] exec_src1_data_i,
    input  logic [ITAG_WIDTH_P-1:0] exec_itag_i,
    input  logic [TID_WIDTH_LP-1:0] exec_tid_i,
    input  mrv_mul_fu_op_e          mul_fu_opc_i,
    input  logic                    mul_fu_req_i,
    output logic                    mul_fu_rdy_o,
    output logic [DATA_WIDTH_P-1:0] mul_fu_res_o,
    output logic                    mul_fu_done_o,
    output logic [ITAG_WIDTH_P-1:0] mul_fu_itag_o,
    output logic [TID_WIDTH_LP-1:0] mul_fu_tid_o,
    input  logic                    mul_fu_wb_rdy_i
);

    localparam int W    = DATA_WIDTH_P;
    localparam int LAST = MUL_STAGES_P - 1;

    logic [MUL_STAGES_P-1:0] pipe_vld;
    logic [2*W-1:0]          pipe_prod [MUL_STAGES_P];
    logic [ITAG_WIDTH_P-1:0] pipe_itag [MUL_STAGES_P];
    logic [TID_WIDTH_LP-1:0] pipe_tid  [MUL_STAGES_P];
    mrv_mul_fu_op_e          pipe_opc  [MUL_STAGES_P];

    logic           advance, mul_accept, a_sign, b_sign;
    logic [2*W-1:0] prod;
    logic [W-1:0]   mul_res;

    assign advance = ~pipe_vld[LAST] | mul_fu_wb_rdy_i;

    // The two top bits of the (W+1)x(W+1) product are never selected, so only 2W bits are formed.
    always_comb begin
        a_sign = (mul_fu_opc_i != MULHU) & exec_src0_data_i[W-1];
        b_sign = ((mul_fu_opc_i == MUL) | (mul_fu_opc_i == MULH)) & exec_src1_data_i[W-1];
        prod   = $signed({{W{a_sign}}, exec_src0_data_i}) * $signed({{W{b_sign}}, exec_src1_data_i});
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MUL_STAGES_P; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_prod[i] <= '0;
                pipe_itag[i] <= '0;
                pipe_tid[i]  <= '0;
                pipe_opc[i]  <= MUL;
            end
        end else if (advance) begin
            pipe_vld[0]  <= mul_accept;
            pipe_prod[0] <= prod;
            pipe_itag[0] <= exec_itag_i;
            pipe_tid[0]  <= exec_tid_i;
            pipe_opc[0]  <= mul_fu_opc_i;
            for (int i = 1; i < MUL_STAGES_P; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_prod[i] <= pipe_prod[i-1];
                pipe_itag[i] <= pipe_itag[i-1];
                pipe_tid[i]  <= pipe_tid[i-1];
                pipe_opc[i]  <= pipe_opc[i-1];
            end
        end
    end

    always_comb begin
        mul_res = '0;
        case (pipe_opc[LAST])
            MUL:                 mul_res = pipe_prod[LAST][W-1:0];
            MULH, MULHSU, MULHU: mul_res = pipe_prod[LAST][2*W-1:W];
            default:             mul_res = '0;
        endcase
    end

`ifdef MRV1_MULDIV_DIV_EN
    logic                    op_is_div, pipe_empty, div_start, div_idle, div_done;
    logic [W-1:0]            div_res;
    logic [ITAG_WIDTH_P-1:0] div_itag;
    logic [TID_WIDTH_LP-1:0] div_tid;

    // A divide only starts once the mul pipeline has drained, so the two never compete for the output.
    assign op_is_div    = is_div_op(mul_fu_opc_i);
    assign pipe_empty   = ~|pipe_vld;
    assign mul_fu_rdy_o = advance & div_idle & (~op_is_div | pipe_empty);
    assign mul_accept   = mul_fu_req_i & mul_fu_rdy_o & ~op_is_div;
    assign div_start    = mul_fu_req_i & mul_fu_rdy_o & op_is_div;

    mrv1_div_iter #(
        .W      (W),
        .ITAG_W (ITAG_WIDTH_P),
        .TID_W  (TID_WIDTH_LP)
    ) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .signed_i   (~mul_fu_opc_i[0]),
        .rem_sel_i  (mul_fu_opc_i[1]),
        .dividend_i (exec_src0_data_i),
        .divisor_i  (exec_src1_data_i),
        .itag_i     (exec_itag_i),
        .tid_i      (exec_tid_i),
        .wb_rdy_i   (mul_fu_wb_rdy_i),
        .idle_o     (div_idle),
        .done_o     (div_done),
        .res_o      (div_res),
        .itag_o     (div_itag),
        .tid_o      (div_tid)
    );

    assign mul_fu_done_o = div_done | pipe_vld[LAST];
    assign mul_fu_res_o  = div_done ? div_res  : mul_res;
    assign mul_fu_itag_o = div_done ? div_itag : pipe_itag[LAST];
    assign mul_fu_tid_o  = div_done ? div_tid  : pipe_tid[LAST];
`else
    assign mul_fu_rdy_o  = advance;
    assign mul_accept    = mul_fu_req_i & mul_fu_rdy_o;
    assign mul_fu_done_o = pipe_vld[LAST];
    assign mul_fu_res_o  = mul_res;
    assign mul_fu_itag_o = pipe_itag[LAST];
    assign mul_fu_tid_o  = pipe_tid[LAST];
`endif

endmodule

// File: tb/tb_mrv1_muldiv_fu.sv
// Self-checking bench for mrv1_muldiv_fu: directed vector table plus stall, divide and reset sequences.
// Divider checks are built only when MRV1_MULDIV_DIV_EN is defined.
module tb_mrv1_muldiv_fu;
    import mrv1_pkg::*;

    localparam int W = 32;
    localparam int S = 2;

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   src0, src1;
    logic [2:0]     itag;
    logic [1:0]     tid;
    mrv_mul_fu_op_e opc;
    logic           req, rdy, done, wb_rdy;
    logic [W-1:0]   res;
    logic [2:0]     itag_o;
    logic [1:0]     tid_o;

    int total;
    int bad;

    typedef struct {
        mrv_mul_fu_op_e opc;
        logic [31:0]    a;
        logic [31:0]    b;
        logic [2:0]     itag;
        logic [1:0]     tid;
        logic [31:0]    exp;
    } vec_t;

    vec_t vecs[$];

    mrv1_muldiv_fu #(
        .DATA_WIDTH_P  (W),
        .ITAG_WIDTH_P  (3),
        .NUM_THREADS_P (4),
        .MUL_STAGES_P  (S)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .exec_src0_data_i (src0),
        .exec_src1_data_i (src1),
        .exec_itag_i      (itag),
        .exec_tid_i       (tid),
        .mul_fu_opc_i     (opc),
        .mul_fu_req_i     (req),
        .mul_fu_rdy_o     (rdy),
        .mul_fu_res_o     (res),
        .mul_fu_done_o    (done),
        .mul_fu_itag_o    (itag_o),
        .mul_fu_tid_o     (tid_o),
        .mul_fu_wb_rdy_i  (wb_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input mrv_mul_fu_op_e o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] it, input logic [1:0] t, input logic r);
        opc  = o;
        src0 = a;
        src1 = b;
        itag = it;
        tid  = t;
        req  = r;
    endtask

    // Called 1 time unit after a rising edge with the FU idle; issues one op and follows it to retirement.
    task automatic runOp(input string name, input mrv_mul_fu_op_e o, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] it, input logic [1:0] t, input logic [31:0] exp,
                         input int exp_lat, input logic busy_chk);
        int   lat;
        logic busy_bad;
        wb_rdy = 1'b1;
        applyStimulus(o, a, b, it, t, 1'b1);
        #1;
        checkOutput({name, " rdy"}, {31'b0, rdy}, 32'd1);
        @(posedge clk); #1;
        applyStimulus(MUL, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0);
        lat      = 1;
        busy_bad = 1'b0;
        while (!done && lat < 64) begin
            if (busy_chk && rdy) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, " done"}, {31'b0, done}, 32'd1);
        if (exp_lat != 0) checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({name, " res"}, res, exp);
        checkOutput({name, " itag"}, {29'b0, itag_o}, {29'b0, it});
        checkOutput({name, " tid"}, {30'b0, tid_o}, {30'b0, t});
        if (busy_chk) checkOutput({name, " busy rdy"}, {31'b0, busy_bad}, 32'd0);
        @(posedge clk); #1;
        checkOutput({name, " retire"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int   issued, got, stall, cyc;
        logic acc, seen;

        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        wb_rdy = 1'b1;
        applyStimulus(MUL, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0);
        #12;
        checkOutput("reset done", {31'b0, done}, 32'd0);
        checkOutput("reset rdy", {31'b0, rdy}, 32'd1);
        checkOutput("reset res", res, 32'd0);
        checkOutput("reset itag", {29'b0, itag_o}, 32'd0);
        checkOutput("reset tid", {30'b0, tid_o}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        vecs.push_back('{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 3'd5, 2'd1, 32'hFFFF_FFEB});
        vecs.push_back('{MULH,   32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 2'd2, 32'h0000_0000});
        vecs.push_back('{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 2'd3, 32'h8000_0000});
        vecs.push_back('{MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 2'd0, 32'h7FFF_FFFF});
        vecs.push_back('{MUL,    32'h1234_5678, 32'h0000_0010, 3'd4, 2'd1, 32'h2345_6780});
        vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 2'd2, 32'hFFFF_FFFE});
        vecs.push_back('{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 2'd3, 32'h0000_0000});
        vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 2'd1, 32'hFFFF_FFFF});
        vecs.push_back('{MULHU,  32'h0001_0000, 32'h0001_0000, 3'd1, 2'd0, 32'h0000_0001});
`ifndef MRV1_MULDIV_DIV_EN
        vecs.push_back('{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 3'd2, 2'd3, 32'h0000_0000});
        vecs.push_back('{REMU,   32'h0000_0005, 32'h0000_0000, 3'd3, 2'd2, 32'h0000_0000});
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].opc, vecs[i].a, vecs[i].b,
                  vecs[i].itag, vecs[i].tid, vecs[i].exp, S, 1'b0);
        end

        // Four back-to-back MULs; writeback refuses the first result for three cycles.
        issued = 0;
        got    = 0;
        stall  = 0;
        cyc    = 0;
        while (got < 4 && cyc < 40) begin
            if (issued < 4)
                applyStimulus(MUL, 32'(issued + 2), 32'(issued + 3), 3'(issued), 2'(issued), 1'b1);
            else
                applyStimulus(MUL, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0);
            if (done && got == 0 && stall < 3) begin
                wb_rdy = 1'b0;
                stall++;
            end else begin
                wb_rdy = 1'b1;
            end
            #1;
            acc = req & rdy;
            if (!wb_rdy) begin
                checkOutput("b2b stall rdy", {31'b0, rdy}, 32'd0);
                checkOutput("b2b hold res", res, 32'd6);
                checkOutput("b2b hold done", {31'b0, done}, 32'd1);
            end
            if (done && wb_rdy) begin
                checkOutput($sformatf("b2b res%0d", got), res, 32'((got + 2) * (got + 3)));
                checkOutput($sformatf("b2b itag%0d", got), {29'b0, itag_o}, 32'(got));
                got++;
            end
            @(posedge clk); #1;
            if (acc) issued++;
            cyc++;
        end
        checkOutput("b2b count", 32'(got), 32'd4);
        checkOutput("b2b stalls", 32'(stall), 32'd3);
        wb_rdy = 1'b1;

`ifdef MRV1_MULDIV_DIV_EN
        runOp("div neg",   DIV,  32'hFFFF_FFF9, 32'h0000_0002, 3'd3, 2'd2, 32'hFFFF_FFFD, W + 1, 1'b1);
        runOp("rem neg",   REM,  32'hFFFF_FFF9, 32'h0000_0002, 3'd4, 2'd1, 32'hFFFF_FFFF, W + 1, 1'b1);
        runOp("divu 100",  DIVU, 32'd100,       32'd7,         3'd5, 2'd3, 32'd14,        W + 1, 1'b1);
        runOp("remu 100",  REMU, 32'd100,       32'd7,         3'd6, 2'd0, 32'd2,         W + 1, 1'b1);
        runOp("divu zero", DIVU, 32'd5,         32'd0,         3'd7, 2'd1, 32'hFFFF_FFFF, 1,     1'b0);
        runOp("rem zero",  REM,  32'd5,         32'd0,         3'd1, 2'd2, 32'd5,         1,     1'b0);
        runOp("div ovf",   DIV,  32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 2'd3, 32'h8000_0000, 0,     1'b0);
        runOp("rem ovf",   REM,  32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 2'd0, 32'h0000_0000, 0,     1'b0);

        // A divide must wait while a multiply is still in the pipeline.
        applyStimulus(MUL, 32'd3, 32'd4, 3'd1, 2'd1, 1'b1);
        @(posedge clk); #1;
        applyStimulus(DIV, 32'd8, 32'd2, 3'd2, 2'd2, 1'b1);
        #1;
        checkOutput("div waits rdy", {31'b0, rdy}, 32'd0);
        applyStimulus(MUL, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("div waits mul res", res, 32'd12);
        @(posedge clk); #1;
`endif

        // Reset with a stalled, full mul pipeline.
        wb_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(MUL, 32'(k + 5), 32'd3, 3'(k + 1), 2'(k + 1), 1'b1);
            @(posedge clk); #1;
        end
        applyStimulus(MUL, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0);
        checkOutput("prefill done", {31'b0, done}, 32'd1);
        rst_n = 1'b0;
        #2;
        checkOutput("mul rst done", {31'b0, done}, 32'd0);
        checkOutput("mul rst rdy", {31'b0, rdy}, 32'd1);
        checkOutput("mul rst res", res, 32'd0);
        checkOutput("mul rst itag", {29'b0, itag_o}, 32'd0);
        checkOutput("mul rst tid", {30'b0, tid_o}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        wb_rdy = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 2 * S + 4; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checkOutput("mul rst stale done", {31'b0, seen}, 32'd0);

`ifdef MRV1_MULDIV_DIV_EN
        // Reset in the middle of a divide.
        applyStimulus(DIVU, 32'd100, 32'd7, 3'd4, 2'd3, 1'b1);
        @(posedge clk); #1;
        applyStimulus(MUL, 32'd0, 32'd0, 3'd0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        checkOutput("div busy rdy", {31'b0, rdy}, 32'd0);
        rst_n = 1'b0;
        #2;
        checkOutput("div rst done", {31'b0, done}, 32'd0);
        checkOutput("div rst rdy", {31'b0, rdy}, 32'd1);
        checkOutput("div rst res", res, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < W + 6; k++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        checkOutput("div rst stale done", {31'b0, seen}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
